// File: rtl/wb1_pkg.sv
// Shared encodings and defaults for the lane-1 write-back stage.
package wb1_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int RIDX_W_DEF  = 5;
  localparam int LINK_OFFSET = 4;

  typedef enum logic [1:0] {
    RFWT_ALU  = 2'd0,
    RFWT_MEM  = 2'd1,
    RFWT_LINK = 2'd2,
    RFWT_ILL  = 2'd3
  } rfwt_sel_e;

endpackage

// File: rtl/wb1_writeback_t_if.sv
// ME1->WB1 stage-register load bus: one D/WE pair per r_wb1_* register plus flush.
interface wb1_writeback_t_if
  import wb1_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int RIDX_W = RIDX_W_DEF
);
  logic [XLEN-1:0]   r_wb1_alu_D;
  logic              r_wb1_alu_WE;
  logic [XLEN-1:0]   r_wb1_memdat_D;
  logic              r_wb1_memdat_WE;
  logic              r_wb1_order_D;
  logic              r_wb1_order_WE;
  logic [XLEN-1:0]   r_wb1_pc_D;
  logic              r_wb1_pc_WE;
  logic [RIDX_W-1:0] r_wb1_rd_D;
  logic              r_wb1_rd_WE;
  logic              r_wb1_regwrite_D;
  logic              r_wb1_regwrite_WE;
  logic [1:0]        r_wb1_rfwt_sel_D;
  logic              r_wb1_rfwt_sel_WE;
  logic              r_wb1_valid_D;
  logic              r_wb1_valid_WE;
  logic              wb1_flush;

  modport master (
    output r_wb1_alu_D, r_wb1_alu_WE, r_wb1_memdat_D, r_wb1_memdat_WE,
           r_wb1_order_D, r_wb1_order_WE, r_wb1_pc_D, r_wb1_pc_WE,
           r_wb1_rd_D, r_wb1_rd_WE, r_wb1_regwrite_D, r_wb1_regwrite_WE,
           r_wb1_rfwt_sel_D, r_wb1_rfwt_sel_WE, r_wb1_valid_D, r_wb1_valid_WE,
           wb1_flush
  );

  modport slave (
    input  r_wb1_alu_D, r_wb1_alu_WE, r_wb1_memdat_D, r_wb1_memdat_WE,
           r_wb1_order_D, r_wb1_order_WE, r_wb1_pc_D, r_wb1_pc_WE,
           r_wb1_rd_D, r_wb1_rd_WE, r_wb1_regwrite_D, r_wb1_regwrite_WE,
           r_wb1_rfwt_sel_D, r_wb1_rfwt_sel_WE, r_wb1_valid_D, r_wb1_valid_WE,
           wb1_flush
  );
endinterface

// File: rtl/wb1_writeback_t_result_mux.sv
// Write-back result select: ALU, memory data, link address (pc+4, wrapping) or 0.
module wb1_result_mux
  import wb1_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] alu,
  input  logic [XLEN-1:0] memdat,
  input  logic [XLEN-1:0] pc,
  input  logic [1:0]      sel,
  output logic [XLEN-1:0] result
);

  // Illegal select yields zero so nothing stale leaks onto the buses.
  always_comb begin
    result = '0;
    case (rfwt_sel_e'(sel))
      RFWT_ALU:  result = alu;
      RFWT_MEM:  result = memdat;
      RFWT_LINK: result = pc + XLEN'(LINK_OFFSET);
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/wb1_writeback_t.sv
// Lane-1 write-back stage: owns r_wb1_* registers, drives RF write port,
// forwarding bus and retire report. Optional retired-instruction counter
// is built when WB1_INSTRET_EN is defined.
module wb1_writeback_t
  import wb1_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int RIDX_W = RIDX_W_DEF,
  parameter int CNT_W  = 64
) (
  input  logic              CLK,
  input  logic              RST,
  wb1_writeback_t_if.slave  me,
  output logic              rf_w1_we,
  output logic [RIDX_W-1:0] rf_w1_addr,
  output logic [XLEN-1:0]   rf_w1_data,
  output logic              fwd_wb1_valid,
  output logic [RIDX_W-1:0] fwd_wb1_rd,
  output logic [XLEN-1:0]   fwd_wb1_data,
  output logic              retire_valid,
  output logic [XLEN-1:0]   retire_pc,
  output logic              retire_order,
  output logic              sel_err
`ifdef WB1_INSTRET_EN
  ,
  output logic [CNT_W-1:0]  instret
`endif
);

  logic [XLEN-1:0]   r_alu, r_memdat, r_pc;
  logic              r_order, r_regwrite, r_valid, fresh;
  logic [RIDX_W-1:0] r_rd;
  logic [1:0]        r_sel;
  logic [XLEN-1:0]   result;
  logic              fire, writes;

  // Data registers: independent loads, each gated only by its own WE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_alu      <= '0;
      r_memdat   <= '0;
      r_pc       <= '0;
      r_order    <= 1'b0;
      r_rd       <= '0;
      r_regwrite <= 1'b0;
      r_sel      <= '0;
    end else begin
      if (me.r_wb1_alu_WE)      r_alu      <= me.r_wb1_alu_D;
      if (me.r_wb1_memdat_WE)   r_memdat   <= me.r_wb1_memdat_D;
      if (me.r_wb1_pc_WE)       r_pc       <= me.r_wb1_pc_D;
      if (me.r_wb1_order_WE)    r_order    <= me.r_wb1_order_D;
      if (me.r_wb1_rd_WE)       r_rd       <= me.r_wb1_rd_D;
      if (me.r_wb1_regwrite_WE) r_regwrite <= me.r_wb1_regwrite_D;
      if (me.r_wb1_rfwt_sel_WE) r_sel      <= me.r_wb1_rfwt_sel_D;
    end
  end

  // Valid/fresh: fresh marks the single cycle after a new load so a stalled
  // (held) instruction retires only once; flush kills the incoming one.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_valid <= 1'b0;
      fresh   <= 1'b0;
    end else begin
      fresh <= me.r_wb1_valid_WE & me.r_wb1_valid_D & ~me.wb1_flush;
      if (me.wb1_flush)           r_valid <= 1'b0;
      else if (me.r_wb1_valid_WE) r_valid <= me.r_wb1_valid_D;
    end
  end

  wb1_result_mux #(.XLEN(XLEN)) u_mux (
    .alu    (r_alu),
    .memdat (r_memdat),
    .pc     (r_pc),
    .sel    (r_sel),
    .result (result)
  );

  assign fire   = r_valid & fresh;
  assign writes = r_regwrite & (r_rd != '0) & (r_sel != RFWT_ILL);

  assign rf_w1_we      = fire & writes;
  assign rf_w1_addr    = r_rd;
  assign rf_w1_data    = result;
  assign fwd_wb1_valid = r_valid & writes;
  assign fwd_wb1_rd    = r_rd;
  assign fwd_wb1_data  = result;
  assign retire_valid  = fire;
  assign retire_pc     = r_pc;
  assign retire_order  = r_order;

  // Sticky flag for a retired instruction carrying the illegal select.
  always_ff @(posedge CLK) begin
    if (RST)                           sel_err <= 1'b0;
    else if (fire && r_sel == RFWT_ILL) sel_err <= 1'b1;
  end

`ifdef WB1_INSTRET_EN
  // Retired-instruction count, silently wrapping.
  always_ff @(posedge CLK) begin
    if (RST)       instret <= '0;
    else if (fire) instret <= instret + 1'b1;
  end
`endif

endmodule

// File: tb/tb_wb1_writeback_t.sv
// Directed bench for wb1_writeback_t; counter checks run when WB1_INSTRET_EN is defined.
module tb_wb1_writeback_t;
  import wb1_pkg::*;

  localparam int XLEN   = 32;
  localparam int RIDX_W = 5;
  localparam int CNT_W  = 4;

  logic              CLK = 1'b0;
  logic              RST;
  logic              rf_w1_we, fwd_wb1_valid, retire_valid, retire_order, sel_err;
  logic [RIDX_W-1:0] rf_w1_addr, fwd_wb1_rd;
  logic [XLEN-1:0]   rf_w1_data, fwd_wb1_data, retire_pc;
`ifdef WB1_INSTRET_EN
  logic [CNT_W-1:0]  instret;
`endif

  int total = 0;
  int bad   = 0;

  wb1_writeback_t_if #(.XLEN(XLEN), .RIDX_W(RIDX_W)) bus ();

  wb1_writeback_t #(.XLEN(XLEN), .RIDX_W(RIDX_W), .CNT_W(CNT_W)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .me            (bus.slave),
    .rf_w1_we      (rf_w1_we),
    .rf_w1_addr    (rf_w1_addr),
    .rf_w1_data    (rf_w1_data),
    .fwd_wb1_valid (fwd_wb1_valid),
    .fwd_wb1_rd    (fwd_wb1_rd),
    .fwd_wb1_data  (fwd_wb1_data),
    .retire_valid  (retire_valid),
    .retire_pc     (retire_pc),
    .retire_order  (retire_order),
    .sel_err       (sel_err)
`ifdef WB1_INSTRET_EN
    ,
    .instret       (instret)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic load(input logic [31:0] alu, input logic [31:0] mem, input logic order,
                      input logic [31:0] pc, input logic [4:0] rd, input logic rw,
                      input logic [1:0] sel, input logic vld);
    bus.r_wb1_alu_D      = alu;  bus.r_wb1_alu_WE      = 1'b1;
    bus.r_wb1_memdat_D   = mem;  bus.r_wb1_memdat_WE   = 1'b1;
    bus.r_wb1_order_D    = order; bus.r_wb1_order_WE   = 1'b1;
    bus.r_wb1_pc_D       = pc;   bus.r_wb1_pc_WE       = 1'b1;
    bus.r_wb1_rd_D       = rd;   bus.r_wb1_rd_WE       = 1'b1;
    bus.r_wb1_regwrite_D = rw;   bus.r_wb1_regwrite_WE = 1'b1;
    bus.r_wb1_rfwt_sel_D = sel;  bus.r_wb1_rfwt_sel_WE = 1'b1;
    bus.r_wb1_valid_D    = vld;  bus.r_wb1_valid_WE    = 1'b1;
    bus.wb1_flush        = 1'b0;
  endtask

  task automatic idle();
    bus.r_wb1_alu_WE      = 1'b0;
    bus.r_wb1_memdat_WE   = 1'b0;
    bus.r_wb1_order_WE    = 1'b0;
    bus.r_wb1_pc_WE       = 1'b0;
    bus.r_wb1_rd_WE       = 1'b0;
    bus.r_wb1_regwrite_WE = 1'b0;
    bus.r_wb1_rfwt_sel_WE = 1'b0;
    bus.r_wb1_valid_WE    = 1'b0;
    bus.wb1_flush         = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"},   64'(rf_w1_we), 64'd0);
    chk({tag, "_data"}, 64'(rf_w1_data), 64'd0);
    chk({tag, "_fwd"},  64'(fwd_wb1_valid), 64'd0);
    chk({tag, "_ret"},  64'(retire_valid), 64'd0);
    chk({tag, "_pc"},   64'(retire_pc), 64'd0);
    chk({tag, "_err"},  64'(sel_err), 64'd0);
`ifdef WB1_INSTRET_EN
    chk({tag, "_cnt"},  64'(instret), 64'd0);
`endif
  endtask

  initial begin
    RST = 1'b1;
    load(32'h0, 32'h0, 1'b0, 32'h0, 5'd0, 1'b0, 2'd0, 1'b0);
    idle();
    step();
    step();
    chk_all_zero("reset");

    // Basic ALU write, then a 3-cycle stall holding the instruction.
    RST = 1'b0;
    load(32'h0000_1234, 32'h0, 1'b1, 32'h0000_0100, 5'd5, 1'b1, 2'd0, 1'b1);
    step();
    chk("alu_we",    64'(rf_w1_we), 64'd1);
    chk("alu_addr",  64'(rf_w1_addr), 64'd5);
    chk("alu_data",  64'(rf_w1_data), 64'h1234);
    chk("alu_ret",   64'(retire_valid), 64'd1);
    chk("alu_rpc",   64'(retire_pc), 64'h100);
    chk("alu_order", 64'(retire_order), 64'd1);
    chk("alu_fwd",   64'(fwd_wb1_valid), 64'd1);
    chk("alu_fwdrd", 64'(fwd_wb1_rd), 64'd5);
    idle();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_ret", 64'(retire_valid), 64'd0);
      chk("stall_we",  64'(rf_w1_we), 64'd0);
      chk("stall_fwd", 64'(fwd_wb1_valid), 64'd1);
      chk("stall_fwdd", 64'(fwd_wb1_data), 64'h1234);
    end
`ifdef WB1_INSTRET_EN
    chk("stall_cnt", 64'(instret), 64'd1);
`endif

    // Link address wraps past the top of the address space.
    load(32'h0, 32'h0, 1'b0, 32'hFFFF_FFFC, 5'd1, 1'b1, 2'd2, 1'b1);
    step();
    chk("link_we",   64'(rf_w1_we), 64'd1);
    chk("link_addr", 64'(rf_w1_addr), 64'd1);
    chk("link_data", 64'(rf_w1_data), 64'h0);

    // Memory data select.
    load(32'h1111_1111, 32'hDEAD_BEEF, 1'b0, 32'h200, 5'd7, 1'b1, 2'd1, 1'b1);
    step();
    chk("mem_we",   64'(rf_w1_we), 64'd1);
    chk("mem_data", 64'(rf_w1_data), 64'hDEAD_BEEF);
    chk("mem_ret",  64'(retire_valid), 64'd1);

    // Flush kills the incoming instruction.
    load(32'h99, 32'h0, 1'b0, 32'h300, 5'd8, 1'b1, 2'd0, 1'b1);
    bus.wb1_flush = 1'b1;
    step();
    chk("flush_we",  64'(rf_w1_we), 64'd0);
    chk("flush_ret", 64'(retire_valid), 64'd0);
    chk("flush_fwd", 64'(fwd_wb1_valid), 64'd0);

    // rd=0 retires without writing.
    load(32'h77, 32'h0, 1'b0, 32'h304, 5'd0, 1'b1, 2'd0, 1'b1);
    step();
    chk("rd0_we",  64'(rf_w1_we), 64'd0);
    chk("rd0_ret", 64'(retire_valid), 64'd1);
    chk("rd0_fwd", 64'(fwd_wb1_valid), 64'd0);

    // regwrite=0 still retires.
    load(32'h66, 32'h0, 1'b1, 32'h308, 5'd3, 1'b0, 2'd0, 1'b1);
    step();
    chk("norw_we",  64'(rf_w1_we), 64'd0);
    chk("norw_ret", 64'(retire_valid), 64'd1);
    chk("norw_rpc", 64'(retire_pc), 64'h308);

    // Illegal select: retires, no write, sticky error from the next cycle.
    load(32'h55, 32'h44, 1'b0, 32'h30C, 5'd4, 1'b1, 2'd3, 1'b1);
    step();
    chk("ill_we",   64'(rf_w1_we), 64'd0);
    chk("ill_ret",  64'(retire_valid), 64'd1);
    chk("ill_data", 64'(rf_w1_data), 64'd0);
    chk("ill_fwd",  64'(fwd_wb1_valid), 64'd0);
    chk("ill_err0", 64'(sel_err), 64'd0);
    idle();
    step();
    chk("ill_err1", 64'(sel_err), 64'd1);
    load(32'h1, 32'h0, 1'b0, 32'h310, 5'd2, 1'b1, 2'd0, 1'b1);
    step();
    chk("ill_err2", 64'(sel_err), 64'd1);
    chk("post_ill_we", 64'(rf_w1_we), 64'd1);

    // Reset during a stall discards the held instruction.
    load(32'h5A, 32'h0, 1'b1, 32'h400, 5'd9, 1'b1, 2'd0, 1'b1);
    step();
    chk("pre_rst_ret", 64'(retire_valid), 64'd1);
    idle();
    step();
    chk("pre_rst_stall_fwd", 64'(fwd_wb1_valid), 64'd1);
    RST = 1'b1;
    step();
    chk_all_zero("midrst");
    RST = 1'b0;
    step();
    chk("post_rst_ret", 64'(retire_valid), 64'd0);
    chk("post_rst_fwd", 64'(fwd_wb1_valid), 64'd0);

    // Flush and reset together: reset wins, same end state.
    load(32'hAB, 32'hCD, 1'b1, 32'h500, 5'd6, 1'b1, 2'd3, 1'b1);
    bus.wb1_flush = 1'b1;
    RST = 1'b1;
    step();
    chk_all_zero("rstflush");
    RST = 1'b0;
    idle();
    step();
    chk("rstflush_ret", 64'(retire_valid), 64'd0);

`ifdef WB1_INSTRET_EN
    // Back-to-back fires fill the counter to all ones, then wrap.
    load(32'h10, 32'h0, 1'b0, 32'h600, 5'd10, 1'b1, 2'd0, 1'b1);
    for (int i = 0; i < (1 << CNT_W); i++) begin
      step();
      chk("burst_ret", 64'(retire_valid), 64'd1);
    end
    idle();
    step();
    chk("cnt_wrap", 64'(instret), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
